// File: rtl/layer2_sequencer_if.sv
// Layer-2 sequencer bus: pass control, weight-2 row handshake and gSRAM/RouteData addressing.
// Latency: none (signal bundle only).
// Backpressure: weight2_loadNextRow is held until w2_row_valid acknowledges the row.
//
// Ports (master = controller side that drives start/w2_row_valid, slave = the sequencer):
//   start, w2_row_valid                  : requests into the sequencer
//   busy, done, weight2_loadNextRow      : status / row request out of the sequencer
//   weight2_addr, route_addr             : weight-2 SRAM address and RouteData index
//   gsram_row, gsram_col, gsram_we,
//   gsram_mux, stage2_gate               : gSRAM accumulator control
//   out_idx                              : current output neuron
interface layer2_sequencer_if #(
    parameter int AW = 4
);
    logic          start;
    logic          w2_row_valid;
    logic          busy;
    logic          done;
    logic          weight2_loadNextRow;
    logic [AW-1:0] weight2_addr;
    logic [AW-1:0] route_addr;
    logic [AW-1:0] gsram_row;
    logic [AW-1:0] gsram_col;
    logic          gsram_we;
    logic          gsram_mux;
    logic          stage2_gate;
    logic [AW-1:0] out_idx;

    modport master (
        output start,
        output w2_row_valid,
        input  busy,
        input  done,
        input  weight2_loadNextRow,
        input  weight2_addr,
        input  route_addr,
        input  gsram_row,
        input  gsram_col,
        input  gsram_we,
        input  gsram_mux,
        input  stage2_gate,
        input  out_idx
    );

    modport slave (
        input  start,
        input  w2_row_valid,
        output busy,
        output done,
        output weight2_loadNextRow,
        output weight2_addr,
        output route_addr,
        output gsram_row,
        output gsram_col,
        output gsram_we,
        output gsram_mux,
        output stage2_gate,
        output out_idx
    );
endinterface

// File: rtl/layer2_sequencer.sv
// Layer-2 pass sequencer: per output neuron fetch a weight-2 row, clear + COLS MACs into gSRAM, sigmoid write-back.
// Latency: all outputs registered; zero-wait pass is 1 + NOUT*(COLS+SIG_LAT+3) + 1 cycles from start to done.
// Backpressure: stalls in REQ_W with weight2_loadNextRow high until w2_row_valid; start ignored while busy.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; abandons any pass in flight without a done pulse
//   l2    : layer2_sequencer_if slave (start/w2_row_valid in; status, addresses and gSRAM controls out)
module layer2_sequencer #(
    parameter int COLS    = 16,
    parameter int NOUT    = 10,
    parameter int AW      = 4,
    parameter int SIG_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    layer2_sequencer_if.slave l2
);

    // Counters are AW bits and must never wrap inside a pass.
    generate
        if (COLS < 1 || COLS > (1 << AW)) begin : g_bad_cols
            $error("layer2_sequencer: COLS must be in 1..2**AW");
        end
        if (NOUT < 1 || NOUT > (1 << AW)) begin : g_bad_nout
            $error("layer2_sequencer: NOUT must be in 1..2**AW");
        end
        if (SIG_LAT < 1 || SIG_LAT > (1 << AW)) begin : g_bad_sig_lat
            $error("layer2_sequencer: SIG_LAT must be in 1..2**AW");
        end
    endgenerate

    localparam logic [AW-1:0] K_LAST   = AW'(COLS - 1);
    localparam logic [AW-1:0] OUT_LAST = AW'(NOUT - 1);
    localparam logic [AW-1:0] SIG_LAST = AW'(SIG_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_W,
        S_CLR,
        S_MAC,
        S_SIG_WAIT,
        S_SIG_WB,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    // k_q counts MAC steps in S_MAC and sigmoid wait cycles in S_SIG_WAIT.
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] out_idx_q, out_idx_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_q, load_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] row_q, row_d;
    logic          we_q, we_d;
    logic          mux_q, mux_d;
    logic          gate_q, gate_d;
    logic          in_stage2;

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        out_idx_d = out_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (l2.start) begin
                    state_d   = S_REQ_W;
                    out_idx_d = '0;
                end
            end
            S_REQ_W: begin
                if (l2.w2_row_valid) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_MAC;
                k_d     = '0;
            end
            S_MAC: begin
                if (k_q == K_LAST) begin
                    state_d = S_SIG_WAIT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_SIG_WAIT: begin
                if (k_q == SIG_LAST) begin
                    state_d = S_SIG_WB;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_SIG_WB: begin
                if (out_idx_q == OUT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_REQ_W;
                    out_idx_d = out_idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered value
    // lines up with the state it describes, with no extra cycle of lag.
    always_comb begin
        in_stage2 = (state_d == S_CLR) || (state_d == S_MAC) ||
                    (state_d == S_SIG_WAIT) || (state_d == S_SIG_WB);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        load_d    = (state_d == S_REQ_W);
        // The clear write uses address 0: RouteData entry 0 is held at zero,
        // so m2result is 0 and the gSRAM entry is cleared.
        addr_d    = (state_d == S_MAC) ? k_d : '0;
        row_d     = in_stage2 ? out_idx_d : '0;
        we_d      = (state_d == S_CLR) || (state_d == S_MAC) || (state_d == S_SIG_WB);
        mux_d     = (state_d == S_SIG_WB);
        gate_d    = in_stage2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            out_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 1'b0;
            addr_q    <= '0;
            row_q     <= '0;
            we_q      <= 1'b0;
            mux_q     <= 1'b0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            out_idx_q <= out_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            load_q    <= load_d;
            addr_q    <= addr_d;
            row_q     <= row_d;
            we_q      <= we_d;
            mux_q     <= mux_d;
            gate_q    <= gate_d;
        end
    end

    // The weight-2 row and the RouteData operand are indexed in lockstep.
    assign l2.busy                = busy_q;
    assign l2.done                = done_q;
    assign l2.weight2_loadNextRow = load_q;
    assign l2.weight2_addr        = addr_q;
    assign l2.route_addr          = addr_q;
    assign l2.gsram_row           = row_q;
    assign l2.gsram_col           = '0;
    assign l2.gsram_we            = we_q;
    assign l2.gsram_mux           = mux_q;
    assign l2.stage2_gate         = gate_q;
    assign l2.out_idx             = out_idx_q;

endmodule
